// File: rtl/handshake_pkg.sv
// handshake_pkg: shared typedefs for handshake pipeline stages
package handshake_pkg;
  typedef enum logic [1:0] {INIT, EMPTY, FULL} hsRegState_t;
endpackage

// File: rtl/handshake_ready_reg.sv
// handshake_ready_reg: one-entry skid buffer that registers the ready path of a valid/ready stream
module handshake_ready_reg
  import handshake_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inValid,
  output logic         inReady,
  input  logic [W-1:0] dIn,
  output logic         outValid,
  input  logic         outReady,
  output logic [W-1:0] dOut,
  input  logic         flush,
  output logic         bufferFull
);
  hsRegState_t state_q, state_d;
  logic [W-1:0] data_q;
  logic capture;
  always_comb begin
    capture  = state_q == EMPTY && inValid && !outReady && !flush;
    state_d  = state_q == INIT ? EMPTY :
               capture ? FULL :
               state_q == FULL && (outReady || flush) ? EMPTY : state_q;
    outValid = state_q == EMPTY ? inValid && !flush : state_q == FULL && !flush;
    dOut     = state_q == FULL ? data_q : dIn;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= INIT;
      inReady    <= 1'b0;
      bufferFull <= 1'b0;
    end else begin
      state_q    <= state_d;
      inReady    <= state_d == EMPTY;
      bufferFull <= state_d == FULL;
    end
  end
  always_ff @(posedge clk)
    if (capture) data_q <= dIn;
endmodule

// File: tb/tb_handshake_ready_reg.sv
// tb_handshake_ready_reg: directed and random self-checking bench for handshake_ready_reg
module tb_handshake_ready_reg;
  logic clk = 1'b0;
  logic rstn, inValid, inReady, outValid, outReady, flush, bufferFull;
  logic [7:0] dIn, dOut;
  int checks = 0;
  int failures = 0;
  logic [7:0] q[$];
  logic ir;

  handshake_ready_reg #(.W(8)) dut (
    .clk(clk), .rstn(rstn), .inValid(inValid), .inReady(inReady), .dIn(dIn),
    .outValid(outValid), .outReady(outReady), .dOut(dOut), .flush(flush),
    .bufferFull(bufferFull)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; inValid = 1'b0; outReady = 1'b0; flush = 1'b0; dIn = 8'h00;
    #1;
    chk("rst_inready", inReady, 0);
    chk("rst_outvalid", outValid, 0);
    chk("rst_full", bufferFull, 0);
    tick; tick;
    rstn = 1'b1;
    #1;
    chk("init_inready", inReady, 0);
    chk("init_outvalid", outValid, 0);
    tick;
    chk("idle_inready", inReady, 1);
    chk("idle_outvalid", outValid, 0);
    chk("idle_full", bufferFull, 0);

    outReady = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      inValid = 1'b1; dIn = 8'(i);
      #1;
      chk("stream_valid", outValid, 1);
      chk("stream_data", dOut, i);
      chk("stream_ready", inReady, 1);
      tick;
    end

    outReady = 1'b0; dIn = 8'hA5;
    #1;
    chk("stall_pass_valid", outValid, 1);
    chk("stall_pass_data", dOut, 8'hA5);
    tick;
    inValid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_full", bufferFull, 1);
      chk("stall_inready", inReady, 0);
      chk("stall_valid", outValid, 1);
      chk("stall_data", dOut, 8'hA5);
      tick;
    end
    outReady = 1'b1; inValid = 1'b1; dIn = 8'h5A;
    #1;
    chk("drain_data", dOut, 8'hA5);
    chk("drain_valid", outValid, 1);
    chk("bubble_inready", inReady, 0);
    tick;
    chk("after_bubble_inready", inReady, 1);
    chk("after_bubble_data", dOut, 8'h5A);
    chk("after_bubble_valid", outValid, 1);
    chk("after_bubble_full", bufferFull, 0);
    tick;

    inValid = 1'b1; dIn = 8'h3C; outReady = 1'b0;
    tick;
    inValid = 1'b0;
    #1;
    chk("fl_full_buf", bufferFull, 1);
    chk("fl_full_data", dOut, 8'h3C);
    flush = 1'b1; outReady = 1'b1;
    #1;
    chk("fl_full_valid", outValid, 0);
    tick;
    flush = 1'b0;
    #1;
    chk("fl_full_inready", inReady, 1);
    chk("fl_full_empty", bufferFull, 0);
    chk("fl_full_nodeliver", outValid, 0);

    inValid = 1'b1; dIn = 8'h77; flush = 1'b1; outReady = 1'b0;
    #1;
    chk("fl_empty_inready", inReady, 1);
    chk("fl_empty_valid", outValid, 0);
    tick;
    flush = 1'b0; inValid = 1'b0;
    #1;
    chk("fl_empty_nocap", bufferFull, 0);
    chk("fl_empty_ready", inReady, 1);
    chk("fl_empty_dropped", outValid, 0);

    inValid = 1'b1; dIn = 8'hEE;
    tick;
    inValid = 1'b0;
    #1;
    chk("ar_full", bufferFull, 1);
    chk("ar_valid_before", outValid, 1);
    rstn = 1'b0;
    #1;
    chk("ar_valid", outValid, 0);
    chk("ar_inready", inReady, 0);
    chk("ar_full_clr", bufferFull, 0);
    outReady = 1'b1;
    tick; tick;
    chk("ar_held_valid", outValid, 0);
    rstn = 1'b1;
    tick; tick;
    chk("ar_rec_inready", inReady, 1);
    chk("ar_rec_nodeliver", outValid, 0);

    for (int c = 0; c < 10000; c++) begin
      inValid = 1'($urandom_range(0, 1));
      dIn = 8'($urandom);
      outReady = 1'($urandom_range(0, 1));
      #1;
      ir = inReady;
      outReady = ~outReady;
      #1;
      chk("ready_iso", inReady, ir);
      outReady = ~outReady;
      #1;
      if (inValid && inReady) q.push_back(dIn);
      if (outValid && outReady) begin
        chk("sb_nonempty", q.size() != 0, 1);
        if (q.size() != 0) chk("sb_data", dOut, q.pop_front());
      end
      tick;
    end
    inValid = 1'b0; outReady = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (outValid) begin
        chk("drain_nonempty", q.size() != 0, 1);
        if (q.size() != 0) chk("drain_sb", dOut, q.pop_front());
      end
      tick;
    end
    chk("sb_lossless", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
